// File: rtl/u765_sd_arbiter.sv
// ---------------------------------------------------------------------------
// u765_sd_arbiter
//
// Shares one SD-card sector channel between NDRV floppy drive emulators.
// Each drive raises a level read or write request with its sector LBA. The
// arbiter grants one drive at a time in round-robin order, strobes the SD
// host until it acknowledges, follows the acknowledge through the transfer,
// and returns a one-cycle done pulse. If the host never acknowledges, the
// served drive gets a one-cycle err pulse instead.
//
// Ports
//   clk_sys   system clock, all state changes on its rising edge
//   reset_n   asynchronous active-low reset
//   ce        clock enable; when low, all state, counters and outputs hold
//   req_rd    per-drive read request (level)
//   req_wr    per-drive write request (level)
//   req_lba   per-drive LBA, drive i at [32i+31:32i]
//   done      one-cycle completion pulse to the served drive
//   err       one-cycle ack-timeout pulse to the served drive
//   busy      high whenever the arbiter is not idle
//   sd_lba    LBA of the active transfer
//   sd_rd     one-hot read strobe to the SD host
//   sd_wr     one-hot write strobe to the SD host
//   sd_ack    SD host acknowledge, high for the whole sector transfer
// ---------------------------------------------------------------------------
module u765_sd_arbiter #(
  parameter int NDRV        = 4,
  parameter int ACK_TIMEOUT = 100
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [NDRV-1:0]      req_rd,
  input  logic [NDRV-1:0]      req_wr,
  input  logic [32*NDRV-1:0]   req_lba,
  output logic [NDRV-1:0]      done,
  output logic [NDRV-1:0]      err,
  output logic                 busy,
  output logic [31:0]          sd_lba,
  output logic [NDRV-1:0]      sd_rd,
  output logic [NDRV-1:0]      sd_wr,
  input  logic                 sd_ack
);

  localparam int GW = (NDRV > 1) ? $clog2(NDRV) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [GW-1:0]   gnt;       // drive currently being served
  logic            op_wr;     // latched op of the active transfer
  logic [GW-1:0]   rr_ptr;    // first drive considered at the next grant
  logic [CW-1:0]   cnt;       // ack timeout counter
  logic            err_pend;  // timeout happened on the last enabled edge

  logic [NDRV-1:0] pend;
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW:0]     idx;
  logic [GW-1:0]   rr_next;
  logic [NDRV-1:0] gnt_oh;
  logic [NDRV-1:0] pick_oh;

  assign pend = req_rd | req_wr;

  // Round-robin search: walk drives rr_ptr, rr_ptr+1, ... wrapping at NDRV,
  // and take the first one with a pending request.
  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NDRV; i++) begin
      idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (idx >= (GW+1)'(NDRV)) idx = idx - (GW+1)'(NDRV);
      if (!found && ((pend >> idx) & NDRV'(1)) != '0) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign pick_oh = NDRV'(1) << pick;
  assign gnt_oh  = NDRV'(1) << gnt;
  assign rr_next = (gnt == GW'(NDRV - 1)) ? '0 : gnt + GW'(1);

  // Outputs decode straight from registered state, so reset clears them
  // immediately without waiting for a clock edge.
  assign busy  = (state != S_IDLE);
  assign sd_rd = (state == S_ISSUE && !op_wr) ? gnt_oh : '0;
  assign sd_wr = (state == S_ISSUE &&  op_wr) ? gnt_oh : '0;
  assign done  = (state == S_DONE) ? gnt_oh : '0;
  assign err   = err_pend ? gnt_oh : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of all the others.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      op_wr    <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
      sd_lba   <= '0;
      err_pend <= 1'b0;
    end else if (ce) begin
      err_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt    <= pick;
            // Write wins when both are requested; the read stays pending
            // and is picked up on a later grant.
            op_wr  <= ((req_wr & pick_oh) != '0);
            sd_lba <= req_lba[32*pick +: 32];
            cnt    <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            cnt   <= '0;
            state <= S_XFER;
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            err_pend <= 1'b1;
            rr_ptr   <= rr_next;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_XFER: begin
          if (!sd_ack) state <= S_DONE;
        end
        S_DONE: begin
          rr_ptr <= rr_next;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_u765_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_u765_sd_arbiter
//
// Directed bench for u765_sd_arbiter with NDRV=4, ACK_TIMEOUT=100. Inputs are
// driven 1 ns after the rising edge and outputs sampled at the same point.
// ---------------------------------------------------------------------------
module tb_u765_sd_arbiter;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         ce;
  logic [3:0]   req_rd;
  logic [3:0]   req_wr;
  logic [127:0] req_lba;
  logic [3:0]   done;
  logic [3:0]   err;
  logic         busy;
  logic [31:0]  sd_lba;
  logic [3:0]   sd_rd;
  logic [3:0]   sd_wr;
  logic         sd_ack;

  int checks   = 0;
  int failures = 0;

  u765_sd_arbiter #(.NDRV(4), .ACK_TIMEOUT(100)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .req_rd  (req_rd),
    .req_wr  (req_wr),
    .req_lba (req_lba),
    .done    (done),
    .err     (err),
    .busy    (busy),
    .sd_lba  (sd_lba),
    .sd_rd   (sd_rd),
    .sd_wr   (sd_wr),
    .sd_ack  (sd_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_reset;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // One full transaction starting from IDLE with requests already set:
  // grant, dly extra ISSUE cycles, ack held for hold cycles, done pulse.
  task automatic serve(input int g, input bit wr, input int dly, input int hold, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    tick;
    check("grant_rd", sd_rd, wr ? 4'b0000 : oh);
    check("grant_wr", sd_wr, wr ? oh : 4'b0000);
    check("grant_busy", busy, 1'b1);
    check("grant_err", err, 4'b0000);
    repeat (dly) tick;
    sd_ack = 1'b1;
    tick;
    check("xfer_strobes", sd_rd | sd_wr, 4'b0000);
    check("xfer_done", done, 4'b0000);
    repeat (hold - 1) tick;
    sd_ack = 1'b0;
    tick;
    check("done_pulse", done, oh);
    if (drop) begin
      if (wr) req_wr[g] = 1'b0;
      else    req_rd[g] = 1'b0;
    end
    tick;
    check("done_clear", done, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ce      = 1'b1;
    reset_n = 1'b1;
    req_rd  = '0;
    req_wr  = '0;
    req_lba = '0;
    sd_ack  = 1'b0;

    // Reset state, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", sd_rd | sd_wr, 4'b0000);
    check("rst_done_err", done | err, 4'b0000);
    check("rst_lba", sd_lba, 32'h0);
    @(negedge clk_sys) reset_n = 1'b1;
    tick;
    check("idle_busy", busy, 1'b0);

    // Single read on drive 1, ack after 5 cycles, held 10 cycles
    req_lba[63:32] = 32'h0000_0123;
    req_rd = 4'b0010;
    tick;
    check("r1_sd_rd", sd_rd, 4'b0010);
    check("r1_sd_wr", sd_wr, 4'b0000);
    check("r1_lba", sd_lba, 32'h0000_0123);
    check("r1_busy", busy, 1'b1);
    req_lba[63:32] = 32'hDEAD_BEEF;
    repeat (4) tick;
    check("r1_rd_held", sd_rd, 4'b0010);
    check("r1_lba_latched", sd_lba, 32'h0000_0123);
    sd_ack = 1'b1;
    tick;
    check("r1_ack_drop", sd_rd, 4'b0000);
    check("r1_xfer_busy", busy, 1'b1);
    req_rd = 4'b0000;            // requester drops after grant
    repeat (9) tick;
    check("r1_no_early_done", done, 4'b0000);
    sd_ack = 1'b0;
    tick;
    check("r1_done", done, 4'b0010);
    tick;
    check("r1_done_once", done, 4'b0000);
    check("r1_busy_fall", busy, 1'b0);

    // Round robin with all four reads held
    pulse_reset();
    req_rd = 4'b1111;
    serve(0, 1'b0, 1, 2, 1'b0);
    serve(1, 1'b0, 0, 1, 1'b0);
    serve(2, 1'b0, 2, 3, 1'b0);
    serve(3, 1'b0, 0, 1, 1'b0);
    serve(0, 1'b0, 1, 1, 1'b0);
    req_rd = 4'b0000;
    tick;
    check("rr_idle", busy, 1'b0);

    // Write and read on the same drive: write first, read next grant
    pulse_reset();
    req_rd = 4'b0010;
    req_wr = 4'b0010;
    serve(1, 1'b1, 1, 2, 1'b1);
    serve(1, 1'b0, 1, 2, 1'b1);
    check("wr_rd_idle", busy, 1'b0);

    // Ack timeout on drive 2, next grant starts at drive 3
    pulse_reset();
    req_wr = 4'b0100;
    req_rd = 4'b1000;
    tick;
    check("to_sd_wr", sd_wr, 4'b0100);
    repeat (99) tick;
    check("to_wr_held_99", sd_wr, 4'b0100);
    check("to_no_err_yet", err, 4'b0000);
    tick;
    check("to_wr_drop", sd_wr, 4'b0000);
    check("to_err", err, 4'b0100);
    check("to_busy", busy, 1'b0);
    req_wr = 4'b0000;
    serve(3, 1'b0, 0, 1, 1'b1);

    // Timeout with ce toggling: 100 enabled cycles = 200 clk_sys cycles
    pulse_reset();
    req_wr = 4'b0100;
    tick;
    check("ce_sd_wr", sd_wr, 4'b0100);
    for (int i = 0; i < 199; i++) begin
      ce = (i % 2 == 1);
      tick;
    end
    check("ce_wr_held_199", sd_wr, 4'b0100);
    check("ce_no_err_yet", err, 4'b0000);
    ce = 1'b1;
    tick;
    check("ce_wr_drop", sd_wr, 4'b0000);
    check("ce_err", err, 4'b0100);
    ce = 1'b0;
    req_wr = 4'b0000;
    tick;
    check("ce_err_hold", err, 4'b0100);
    ce = 1'b1;
    tick;
    check("ce_err_clear", err, 4'b0000);
    check("ce_idle", busy, 1'b0);

    // Reset during XFER: async clear, no done, re-arbitration from drive 0
    pulse_reset();
    req_rd = 4'b0110;
    serve(1, 1'b0, 0, 1, 1'b0);
    tick;
    check("mr_grant2", sd_rd, 4'b0100);
    sd_ack = 1'b1;
    tick;
    check("mr_xfer_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mr_async_busy", busy, 1'b0);
    check("mr_async_strobes", sd_rd | sd_wr, 4'b0000);
    check("mr_no_done", done | err, 4'b0000);
    #1;
    reset_n = 1'b1;
    sd_ack  = 1'b0;
    tick;
    check("mr_regrant_from0", sd_rd, 4'b0010);
    check("mr_regrant_done", done, 4'b0000);
    req_rd = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
